// File: rtl/pc_deser_pkg.sv
// Shared constants and types for the bit-sliced PC word deserializer.
package pc_deser_pkg;

  localparam int unsigned LANES  = 8;
  localparam int unsigned LANE_W = 8;
  localparam int unsigned WORD_W = LANES * LANE_W;

  localparam logic DIR_MSB_FIRST = 1'b1;
  localparam logic DIR_LSB_FIRST = 1'b0;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } asm_state_t;

endpackage

// File: rtl/pc_lane_deser.sv
// One byte lane: serial bit shifted in per accepted beat, either order.
module pc_lane_deser
  import pc_deser_pkg::*;
#(
  parameter int unsigned W = pc_deser_pkg::LANE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         dir,
  input  logic         sin,
  input  logic         clr,
  output logic [W-1:0] q
);

  // Shift register: clear on reset/flush, otherwise shift in on enable.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      if (dir == DIR_MSB_FIRST) q <= {q[W-2:0], sin};
      else                      q <= {sin, q[W-1:1]};
    end
  end

endmodule

// File: rtl/pc_deser.sv
// Receive-side deserializer: LANES serial bits per beat, LANE_W beats per
// word, completed word handed off through a one-deep valid/ready register.
module pc_deser
  import pc_deser_pkg::*;
#(
  parameter  int unsigned LANES  = pc_deser_pkg::LANES,
  parameter  int unsigned LANE_W = pc_deser_pkg::LANE_W,
  localparam int unsigned WORD_W = LANES * LANE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dir,
  input  logic              in_valid,
  input  logic [LANES-1:0]  lane_bits,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] word,
  output logic [2:0]        beat_cnt
);

  localparam logic [2:0] LAST = 3'(LANE_W - 1);

  asm_state_t              state;
  logic                    dir_lat;
  logic                    eff_dir;
  logic                    accept;
  logic                    complete;
  logic [LANE_W-1:0]       lane_q [LANES];
  logic [WORD_W-1:0]       asm_next;

  // Only the completing beat stalls, and only while the held word is not leaving.
  assign in_ready = !((beat_cnt == LAST) && out_valid && !out_ready);

  // A beat coinciding with flush is dropped.
  assign accept   = in_valid && in_ready && !flush;
  assign complete = accept && (beat_cnt == LAST);

  // First beat of a word uses the live dir; the rest use the latched copy.
  assign eff_dir  = (state == IDLE) ? dir : dir_lat;

  for (genvar k = 0; k < int'(LANES); k++) begin : g_lane
    pc_lane_deser #(.W(LANE_W)) u_lane (
      .clk (clk),
      .rst (rst),
      .en  (accept),
      .dir (eff_dir),
      .sin (lane_bits[k]),
      .clr (flush),
      .q   (lane_q[k])
    );

    // Lane value after the current beat, so the completing beat reaches the
    // output register in the same edge that accepts it.
    assign asm_next[k*LANE_W +: LANE_W] = (eff_dir == DIR_MSB_FIRST)
      ? {lane_q[k][LANE_W-2:0], lane_bits[k]}
      : {lane_bits[k], lane_q[k][LANE_W-1:1]};
  end

  // Assembly FSM: beat counter and dir latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      dir_lat  <= DIR_LSB_FIRST;
    end else if (flush) begin
      state    <= IDLE;
      beat_cnt <= '0;
    end else if (accept) begin
      if (state == IDLE) dir_lat <= dir;
      if (beat_cnt == LAST) begin
        state    <= IDLE;
        beat_cnt <= '0;
      end else begin
        state    <= COLLECT;
        beat_cnt <= beat_cnt + 3'd1;
      end
    end
  end

  // Output register: a completing word wins over a draining handshake,
  // giving bubble-free back-to-back transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      word      <= '0;
    end else if (complete) begin
      out_valid <= 1'b1;
      word      <= asm_next;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_deser.sv
// Self-checking bench for pc_deser: directed scenarios plus randomized
// traffic checked against a queue-based word model.
module tb_pc_deser;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dir = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  lane_bits = '0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] word;
  logic [2:0]  beat_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  pc_deser dut (
    .clk       (clk),
    .rst       (rst),
    .dir       (dir),
    .in_valid  (in_valid),
    .lane_bits (lane_bits),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .word      (word),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: beats are kept as a list; a word is built from the
  // list once eight have arrived, placing beat j at bit 7-j or bit j.
  logic [7:0]  mbeats [$];
  logic [63:0] mout   [$];
  logic        mdir = 1'b0;

  always @(posedge clk) begin
    bit          mir;
    logic [63:0] w;
    if (rst) begin
      mbeats.delete();
      mout.delete();
      mdir = 1'b0;
    end else begin
      mir = !(mbeats.size() == 7 && mout.size() != 0 && !out_ready);
      if (mout.size() != 0 && out_ready) void'(mout.pop_front());
      if (flush) begin
        mbeats.delete();
      end else if (in_valid && mir) begin
        if (mbeats.size() == 0) mdir = dir;
        mbeats.push_back(lane_bits);
        if (mbeats.size() == 8) begin
          w = '0;
          for (int j = 0; j < 8; j++)
            for (int k = 0; k < 8; k++)
              if (mdir) w[8*k + 7 - j] = mbeats[j][k];
              else      w[8*k + j]     = mbeats[j][k];
          mout.push_back(w);
          mbeats.delete();
        end
      end
    end
  end

  // Lane bits of beat j for target word w sent in order d.
  function automatic logic [7:0] gen(input logic [63:0] w, input logic d, input int j);
    logic [7:0] r;
    for (int k = 0; k < 8; k++)
      r[k] = d ? w[8*k + 7 - j] : w[8*k + j];
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drives beats first..last of word w; optionally flips dir from beat 3 on.
  task automatic send_beats(input logic [63:0] w, input logic d,
                            input int first, input int last, input bit toggle);
    for (int j = first; j <= last; j++) begin
      in_valid  = 1'b1;
      lane_bits = gen(w, d, j);
      dir       = (toggle && j >= 3) ? ~d : d;
      cyc();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    cyc();
    cyc();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
    else n_pass++;
    n_checks++;
    if (word !== 64'h0) $display("FAIL reset_word got %h want 0", word);
    else n_pass++;
    n_checks++;
    if (beat_cnt !== 3'd0) $display("FAIL reset_beat_cnt got %0d want 0", beat_cnt);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_msb_first();
    logic [63:0] w = 64'h0123456789ABCDEF;
    send_beats(w, 1'b1, 0, 6, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || beat_cnt !== 3'd7)
      $display("FAIL msb_before_last got valid=%b cnt=%0d want valid=0 cnt=7", out_valid, beat_cnt);
    else n_pass++;
    send_beats(w, 1'b1, 7, 7, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || word !== w)
      $display("FAIL msb_word got valid=%b word=%h want valid=1 word=%h", out_valid, word, w);
    else n_pass++;
    n_checks++;
    if (beat_cnt !== 3'd0) $display("FAIL msb_cnt_wrap got %0d want 0", beat_cnt);
    else n_pass++;
    drain();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL msb_consumed got valid=%b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_lsb_first();
    logic [63:0] w = 64'hFEDCBA9876543210;
    send_beats(w, 1'b0, 0, 7, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || word !== w)
      $display("FAIL lsb_dir_toggle got valid=%b word=%h want valid=1 word=%h", out_valid, word, w);
    else n_pass++;
  endtask

  // Word A (from the LSB test) is held while word B streams in.
  task automatic test_backpressure();
    logic [63:0] a = 64'hFEDCBA9876543210;
    logic [63:0] b = 64'h5A5AC3C3_1234_F00D;
    out_ready = 1'b0;
    for (int j = 0; j < 7; j++) begin
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL bp_in_ready_beat%0d got %b want 1", j, in_ready);
      else n_pass++;
      send_beats(b, 1'b1, j, j, 1'b0);
    end
    in_valid  = 1'b1;
    lane_bits = gen(b, 1'b1, 7);
    dir       = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL bp_stall got in_ready=%b want 0", in_ready);
    else n_pass++;
    cyc();
    cyc();
    n_checks++;
    if (out_valid !== 1'b1 || word !== a || beat_cnt !== 3'd7)
      $display("FAIL bp_hold got valid=%b word=%h cnt=%0d want valid=1 word=%h cnt=7",
               out_valid, word, beat_cnt, a);
    else n_pass++;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL bp_release got in_ready=%b want 1", in_ready);
    else n_pass++;
    cyc();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || word !== b)
      $display("FAIL bp_no_bubble got valid=%b word=%h want valid=1 word=%h", out_valid, word, b);
    else n_pass++;
    cyc();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL bp_drained got valid=%b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] ws [2] = '{64'hAAAA5555AAAA5555, 64'h0F0F0F0F0F0F0F0F};
    int          valid_cycles = 0;
    bit          want_v;
    out_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      in_valid  = 1'b1;
      lane_bits = gen(ws[n/8], 1'b1, n % 8);
      dir       = 1'b1;
      cyc();
      want_v = (n % 8 == 7);
      if (out_valid === 1'b1) valid_cycles++;
      n_checks++;
      if (out_valid !== want_v || (want_v && word !== ws[n/8]))
        $display("FAIL b2b_beat%0d got valid=%b word=%h want valid=%b word=%h",
                 n, out_valid, word, want_v, ws[n/8]);
      else n_pass++;
    end
    in_valid = 1'b0;
    cyc();
    if (out_valid === 1'b1) valid_cycles++;
    n_checks++;
    if (valid_cycles != 2) $display("FAIL b2b_throughput got %0d valid cycles want 2", valid_cycles);
    else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    logic [63:0] w = 64'h1122334455667788;
    send_beats(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 2, 1'b0);
    n_checks++;
    if (beat_cnt !== 3'd3) $display("FAIL flush_pre_cnt got %0d want 3", beat_cnt);
    else n_pass++;
    flush     = 1'b1;
    in_valid  = 1'b1;
    lane_bits = 8'hFF;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL flush_in_ready got %b want 1", in_ready);
    else n_pass++;
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (beat_cnt !== 3'd0 || out_valid !== 1'b0)
      $display("FAIL flush_clear got cnt=%0d valid=%b want cnt=0 valid=0", beat_cnt, out_valid);
    else n_pass++;
    send_beats(w, 1'b1, 0, 7, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || word !== w)
      $display("FAIL flush_word got valid=%b word=%h want valid=1 word=%h", out_valid, word, w);
    else n_pass++;
    drain();
  endtask

  task automatic test_reset_mid();
    logic [63:0] w1 = 64'hDEADBEEFCAFEF00D;
    logic [63:0] w2 = 64'h0123456789ABCDEF;
    out_ready = 1'b0;
    send_beats(w1, 1'b1, 0, 7, 1'b0);
    send_beats(w2, 1'b1, 0, 4, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || beat_cnt !== 3'd5)
      $display("FAIL rstmid_pre got valid=%b cnt=%0d want valid=1 cnt=5", out_valid, beat_cnt);
    else n_pass++;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || word !== 64'h0 || beat_cnt !== 3'd0 || in_ready !== 1'b1)
      $display("FAIL rstmid_state got valid=%b word=%h cnt=%0d rdy=%b want 0/0/0/1",
               out_valid, word, beat_cnt, in_ready);
    else n_pass++;
    send_beats(w2, 1'b0, 0, 7, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || word !== w2)
      $display("FAIL rstmid_word got valid=%b word=%h want valid=1 word=%h", out_valid, word, w2);
    else n_pass++;
    drain();
  endtask

  task automatic test_random();
    bit want_rdy;
    for (int c = 0; c < 600; c++) begin
      n_checks++;
      if (out_valid !== (mout.size() != 0) ||
          (mout.size() != 0 && word !== mout[0]) ||
          beat_cnt !== 3'(mbeats.size()))
        $display("FAIL rand_c%0d got valid=%b word=%h cnt=%0d want valid=%b word=%h cnt=%0d",
                 c, out_valid, word, beat_cnt, mout.size() != 0,
                 (mout.size() != 0) ? mout[0] : 64'h0, mbeats.size());
      else n_pass++;
      in_valid  = ($urandom_range(0, 3) != 0);
      lane_bits = 8'($urandom);
      dir       = 1'($urandom);
      out_ready = ($urandom_range(0, 2) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      #1;
      want_rdy = !(mbeats.size() == 7 && mout.size() != 0 && !out_ready);
      n_checks++;
      if (in_ready !== want_rdy)
        $display("FAIL rand_rdy_c%0d got %b want %b", c, in_ready, want_rdy);
      else n_pass++;
      cyc();
    end
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
